// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor, D = A - B - borrow_in, LSB first; SUB_SERIAL_OVF_EN adds o_ovf.
// Rev 1.0
`default_nettype none

module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_in,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_d,
  output logic             o_b
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_busy  = (state == RUN);
    o_valid = (state == DONE);
  end

  // The minuend register doubles as the result register: difference bits
  // enter at the MSB as minuend bits leave at the LSB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      o_d   <= '0;
      o_b   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      o_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sr <= i_a;
            b_sr <= i_b;
            br   <= i_b_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= {d_bit, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            o_d   <= {d_bit, a_sr[WIDTH-1:1]};
            o_b   <= br_next;
`ifdef SUB_SERIAL_OVF_EN
            // On the last bit the shift registers hold the operand MSBs.
            o_ovf <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
